// File: rtl/sync_ram_init.sv
// Single-port synchronous RAM with byte enables, optional output register
// and a hardware init sweep that runs after reset or soft clear.
module sync_ram_init #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    rd_valid,
  output logic                    ready
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  run;
  logic                  acc;
  logic                  init_last;
  logic [DATA_WIDTH-1:0] rdata;

  assign run       = (state == S_RUN);
  assign ready     = run;
  assign acc       = run & ~clr;
  assign init_last = (init_ptr == {ADDR_WIDTH{1'b1}});
  assign rdata     = mem[addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_ptr <= '0;
    end else begin
      unique case (1'b1)
        (state == S_INIT): begin
          init_ptr <= init_ptr + ADDR_WIDTH'(1);
          if (init_last)
            state <= S_RUN;
        end
        (state == S_RUN): begin
          if (clr) begin
            state    <= S_INIT;
            init_ptr <= '0;
          end
        end
        default: begin
          state    <= S_INIT;
          init_ptr <= '0;
        end
      endcase
    end
  end

  // Array has no reset; the sweep defines every word before ready rises.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) begin
        mem[init_ptr] <= INIT_VALUE;
      end else if (acc && we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i])
            mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] s1_data;
      logic                  s1_v;

      // A clear edge drops whatever sits in the first stage.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_data  <= '0;
          s1_v     <= 1'b0;
          dout     <= '0;
          rd_valid <= 1'b0;
        end else if (!acc) begin
          s1_v     <= 1'b0;
          rd_valid <= 1'b0;
        end else begin
          s1_v     <= re;
          rd_valid <= s1_v;
          if (re)
            s1_data <= rdata;
          if (s1_v)
            dout <= s1_data;
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout     <= '0;
          rd_valid <= 1'b0;
        end else if (acc && re) begin
          dout     <= rdata;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
